// File: rtl/am_sdr_pkg.sv
// Shared constants for the 1-bit AM receiver datapath: CIC decimation
// ratio, stage count, accumulator width derivation and the CIC DC gain.
package am_sdr_pkg;

  localparam int LOG2_DECIM_DEF = 6;
  localparam int STAGES         = 3;

  // Bit growth of an N-stage CIC is N*log2(R); two extra bits hold the
  // sign and the full-scale +/-R^N result without ambiguity.
  function automatic int acc_width(input int stages, input int log2r);
    return stages * log2r + 2;
  endfunction

  localparam int ACC_W_DEF = acc_width(STAGES, LOG2_DECIM_DEF);
  localparam int CIC_GAIN  = 2 ** (STAGES * LOG2_DECIM_DEF);

endpackage

// File: rtl/am_cic_decimator.sv
// Three-stage CIC decimator (differential delay 1) turning the mixed 1-bit
// +1/-1 stream of one channel into signed baseband words at fs/R.
// All arithmetic wraps modulo 2^ACC_W; the combs cancel the integrator
// overflow, so no saturation is used anywhere.
module am_cic_decimator
  import am_sdr_pkg::*;
#(
  parameter int LOG2_DECIM = LOG2_DECIM_DEF,
  localparam int ACC_W     = acc_width(STAGES, LOG2_DECIM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid
);

  logic signed [ACC_W-1:0] i1, i2, i3;
  logic signed [ACC_W-1:0] z1, z2, z3;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic [LOG2_DECIM-1:0]   cnt;
  logic                    dec_event;

  // Input mapping (+1/-1) and the decimation event: last sample of a window.
  always_comb begin
    x         = in_bit ? ACC_W'(1) : {ACC_W{1'b1}};
    dec_event = in_valid && (cnt == {LOG2_DECIM{1'b1}});
  end

  // Comb chain evaluated on the pre-update i3 within the event cycle.
  always_comb begin
    c1 = i3 - z1;
    c2 = c1 - z2;
    c3 = c2 - z3;
  end

  // Pipelined integrators and window counter, advancing only on valid samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      i1  <= i1 + x;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      cnt <= cnt + LOG2_DECIM'(1);
    end
  end

  // Comb delay update and registered output, one pulse per decimation event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z1        <= '0;
      z2        <= '0;
      z3        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dec_event;
      if (dec_event) begin
        z1       <= i3;
        z2       <= c1;
        z3       <= c2;
        out_data <= c3;
      end
    end
  end

endmodule

// File: doc/am_cic_decimator.md
Name: am_cic_decimator

Overview:
- Decimation stage directly downstream of the 1-bit mixer in the tiny 1-bit AM receiver.
- Consumes the mixed 1-bit sample stream (one channel, I or Q), which represents +1/-1.
- Applies a 3-stage CIC decimator with differential delay 1 and emits signed baseband words at fs/DECIM to the envelope (magnitude) stage.
- The top level instantiates two copies, one for I and one for Q.

Parameters:
- LOG2_DECIM, 6, log2 of decimation ratio R (R = 64).
- STAGES, 3, number of integrator and comb stages N. Fixed at 3; the RTL need not support other values.
- ACC_W, 20, accumulator and output width = N*LOG2_DECIM + 2. Derived; must not be overridden independently.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  input sample strobe, one sample per high cycle.
- in_bit  input  1  sample: 1 means +1, 0 means -1.
- out_data  output  ACC_W  signed two's-complement decimated sample.
- out_valid  output  1  one-cycle pulse; out_data is new when high.

Behaviour:
- Reset, when rst_n is low at a clk edge, clears to 0:
  - integrators i1, i2, i3
  - decimation counter cnt
  - comb delay registers z1, z2, z3
  - out_data and out_valid
- Reset has priority over in_valid. No out_valid pulse occurs in the reset cycle or the following cycle. Reset mid-operation discards all state.
- Input mapping: x = in_bit ? +1 : -1, sign-extended to ACC_W.
- Integrators are pipelined and update only on in_valid cycles, using previous register values:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- When in_valid is low, all state holds.
- Arithmetic is modulo 2^ACC_W. Wrap-around is intentional and required for CIC correctness. No saturation anywhere.
- cnt (LOG2_DECIM bits) increments on each in_valid and wraps from R-1 to 0.
- Decimation event: in_valid high and cnt == R-1. Then d = i3 as registered before that cycle's update.
- Combs are combinational within the event cycle:
  - c1 = d - z1
  - c2 = c1 - z2
  - c3 = c2 - z3
  - then z1 <= d, z2 <= c1, z3 <= c2
  - out_data <= c3
  - out_valid <= 1 on the next edge
- Latency: out_valid is high exactly one cycle after the decimation-event cycle. It is low in all other cycles.
- out_data holds its value between pulses.
- Output rate: exactly one pulse per R in_valid cycles, regardless of gaps in in_valid.
- Gain is R^N = 2^18 = 262144.
  - Constant +1 input settles to +262144.
  - Constant -1 input settles to -262144.
  - Both fit in 20-bit signed.
- Settling: the step response is exact from the 5th out_valid after reset onward. The 1st through 4th outputs are monotonic toward the final value.

Decomposition:
- Shared package am_sdr_pkg holds:
  - LOG2_DECIM default
  - STAGES
  - ACC_W derivation function (N*log2R + 2)
  - constant CIC_GAIN = 2**(STAGES*LOG2_DECIM)
- The same package supplies widths to the downstream magnitude stage.
- No sub-module. Integrators and combs are small enough to live inline; a generate loop per stage is acceptable.

Test Plan:
- Reset, then in_bit=1 with in_valid=1 every cycle for 640 cycles -> exactly 10 out_valid pulses spaced 64 cycles apart; the 5th through 10th each equal 262144.
- Reset, then in_bit=0 continuously for 640 cycles -> the 5th through 10th outputs equal -262144 (0xC0000 in 20 bits).
- Alternating in_bit 1,0,1,0 continuously -> from the 5th output onward |out_data| <= 64; the sequence stays bounded with no drift.
- Constant in_bit=1 with in_valid high only every 3rd cycle -> pulses every 192 cycles; values are identical to the dense-strobe case (5th onward = 262144).
- rst_n low for 1 cycle in the middle of a decimation window, then in_bit=1 -> no pulse in the reset cycle; the next pulse comes 64 valid samples after reset release; output is 262144 from the 5th post-reset pulse.
- Long run of 10^6 cycles at in_bit=1 (integrators wrap many times) -> every output from the 5th onward is still 262144, proving modulo arithmetic is correct.
